// File: rtl/gpio_bank_if.sv
// Core-side register access bus for gpio_bank: port select, write strobes and read path.
interface gpio_bank_if #(
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            portSel;
  logic                  wrLatch;
  logic                  wrTris;
  logic                  rdEn;
  logic [DATA_WIDTH-1:0] wrData;
  logic [DATA_WIDTH-1:0] rdData;

  modport master (output portSel, wrLatch, wrTris, rdEn, wrData, input rdData);
  modport slave  (input portSel, wrLatch, wrTris, rdEn, wrData, output rdData);
endinterface

// File: rtl/gpio_bank.sv
// Bank of NUM_PORTS GPIO ports: output latch, TRIS, 2-flop pad sync, registered read.
// Optional change-on-input flags are built only when GPIO_CHANGE_IRQ_EN is defined.

module gpio_bank_port #(
  parameter int PORT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_WIDTH-1:0] pinIn,
  input  logic                  wrLatch,
  input  logic                  wrTris,
  input  logic [PORT_WIDTH-1:0] wrData,
  output logic [PORT_WIDTH-1:0] latch,
  output logic [PORT_WIDTH-1:0] tris,
  output logic [PORT_WIDTH-1:0] sync2
);
  logic [PORT_WIDTH-1:0] sync1;

  // TRIS resets to all ones so every pad comes up as an input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch <= '0;
      tris  <= '1;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      if (wrLatch) latch <= wrData;
      if (wrTris)  tris  <= wrData;
      sync1 <= pinIn;
      sync2 <= sync1;
    end
  end
endmodule

module gpio_bank #(
  parameter int NUM_PORTS  = 3,
  parameter int PORT_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  gpio_bank_if.slave                      bus,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] pinIn,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pinOut,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pinOe,
  output logic [NUM_PORTS-1:0]            changeIrq
);
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] latchArr;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] trisArr;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] sync2Arr;
  logic [NUM_PORTS-1:0]                 hit;
  logic [PORT_WIDTH-1:0]                rdMux;

  // An out-of-range portSel matches no port, so writes drop and reads mux to zero.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
    assign hit[p] = (int'(bus.portSel) == p);

    gpio_bank_port #(.PORT_WIDTH(PORT_WIDTH)) uPort (
      .clk     (clk),
      .rst     (rst),
      .pinIn   (pinIn[p*PORT_WIDTH +: PORT_WIDTH]),
      .wrLatch (bus.wrLatch && hit[p]),
      .wrTris  (bus.wrTris && hit[p]),
      .wrData  (bus.wrData[PORT_WIDTH-1:0]),
      .latch   (latchArr[p]),
      .tris    (trisArr[p]),
      .sync2   (sync2Arr[p])
    );
  end

  assign pinOut = latchArr;
  assign pinOe  = ~trisArr;

  // Reads see synchronised pad state, never the latch, so RMW reflects the pads.
  always_comb begin
    rdMux = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (hit[p]) rdMux = sync2Arr[p];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            bus.rdData <= '0;
    else if (bus.rdEn)  bus.rdData <= DATA_WIDTH'(rdMux);
  end

`ifdef GPIO_CHANGE_IRQ_EN
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] snap;
  logic [NUM_PORTS-1:0]                 irqQ;

  // A read re-arms the port: the clear wins over any mismatch seen in that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
      irqQ <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.rdEn && hit[p]) begin
          snap[p] <= sync2Arr[p];
          irqQ[p] <= 1'b0;
        end else if (|(trisArr[p] & (sync2Arr[p] ^ snap[p]))) begin
          irqQ[p] <= 1'b1;
        end
      end
    end
  end

  assign changeIrq = irqQ;
`else
  assign changeIrq = '0;
`endif
endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank (3 ports x 8 pins); flag expectations follow GPIO_CHANGE_IRQ_EN.
module tb_gpio_bank;
  localparam int NP = 3;
  localparam int PW = 8;
  localparam int DW = 8;
`ifdef GPIO_CHANGE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           clkEn = 1'b0;
  logic           rst = 1'b0;
  logic [NP*PW-1:0] pinIn;
  logic [NP*PW-1:0] pinOut;
  logic [NP*PW-1:0] pinOe;
  logic [NP-1:0]    changeIrq;
  int compared = 0;
  int mismatched = 0;

  gpio_bank_if #(.DATA_WIDTH(DW)) bus ();

  gpio_bank #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pinIn     (pinIn),
    .pinOut    (pinOut),
    .pinOe     (pinOe),
    .changeIrq (changeIrq)
  );

  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wrLatch = 1'b0;
    bus.wrTris  = 1'b0;
    bus.rdEn    = 1'b0;
  endtask

  initial begin
    idle();
    bus.portSel = 2'd0;
    bus.wrData  = '0;
    pinIn       = '0;

    // Reset with no clock running
    #2 rst = 1'b1;
    #1;
    chk("rst_pinOut", 32'(pinOut), 32'h0);
    chk("rst_pinOe", 32'(pinOe), 32'h0);
    chk("rst_rdData", 32'(bus.rdData), 32'h0);
    chk("rst_irq", 32'(changeIrq), 32'h0);
    clkEn = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Port 1 as output
    bus.portSel = 2'd1; bus.wrTris = 1'b1; bus.wrData = 8'h00;
    tick();
    bus.wrTris = 1'b0; bus.wrLatch = 1'b1; bus.wrData = 8'hA5;
    tick();
    idle();
    chk("p1_pinOut", 32'(pinOut[15:8]), 32'hA5);
    chk("p1_pinOe", 32'(pinOe[15:8]), 32'hFF);
    chk("p0_pinOe", 32'(pinOe[7:0]), 32'h00);

    // Simultaneous latch and TRIS write, then restore port 0 to input
    bus.portSel = 2'd0; bus.wrLatch = 1'b1; bus.wrTris = 1'b1; bus.wrData = 8'h5A;
    tick();
    idle();
    chk("both_pinOut", 32'(pinOut[7:0]), 32'h5A);
    chk("both_pinOe", 32'(pinOe[7:0]), 32'hA5);
    bus.wrTris = 1'b1; bus.wrData = 8'hFF;
    tick();
    idle();
    chk("restore_pinOe", 32'(pinOe[7:0]), 32'h00);

    // Synchroniser latency on port 0
    pinIn[7:0] = 8'h3C;
    bus.portSel = 2'd0; bus.rdEn = 1'b1;
    tick();
    chk("sync_rd1", 32'(bus.rdData), 32'h00);
    tick();
    chk("sync_rd2", 32'(bus.rdData), 32'h00);
    tick();
    chk("sync_rd3", 32'(bus.rdData), 32'h3C);
    idle();
    pinIn[7:0] = 8'h11;
    tick(); tick(); tick();
    chk("rd_hold", 32'(bus.rdData), 32'h3C);

    // Read and write to the same port in one cycle: no bypass
    bus.rdEn = 1'b1; bus.wrLatch = 1'b1; bus.wrData = 8'hEE;
    tick();
    idle();
    chk("rw_rdData", 32'(bus.rdData), 32'h11);
    chk("rw_pinOut", 32'(pinOut[7:0]), 32'hEE);

    // Change flag on port 2, low nibble inputs
    bus.portSel = 2'd2; bus.wrTris = 1'b1; bus.wrData = 8'h0F;
    tick();
    idle();
    pinIn[20] = 1'b1;
    tick(); tick(); tick();
    chk("irq_outbit", 32'(changeIrq[2]), 32'h0);
    pinIn[16] = 1'b1;
    tick(); tick();
    chk("irq_2edges", 32'(changeIrq[2]), 32'h0);
    tick();
    chk("irq_set", 32'(changeIrq[2]), 32'(IRQ_ON));
    bus.rdEn = 1'b1;
    tick();
    idle();
    chk("irq_clr", 32'(changeIrq[2]), 32'h0);
    chk("irq_rdData", 32'(bus.rdData), 32'h11);
    tick();
    chk("irq_stay_clr", 32'(changeIrq[2]), 32'h0);
    pinIn[17] = 1'b1;
    tick(); tick(); tick();
    chk("irq_reset", 32'(changeIrq[2]), 32'(IRQ_ON));

    // Illegal port index
    bus.portSel = 2'd3; bus.wrLatch = 1'b1; bus.wrTris = 1'b1; bus.wrData = 8'hFF;
    tick();
    idle();
    chk("bad_pinOut", 32'(pinOut), 32'h00A5EE);
    chk("bad_pinOe", 32'(pinOe), 32'hF0FF00);
    bus.rdEn = 1'b1;
    tick();
    idle();
    chk("bad_rdData", 32'(bus.rdData), 32'h0);

    // Reset mid-access aborts the write
    bus.portSel = 2'd1; bus.wrLatch = 1'b1; bus.wrData = 8'h3C;
    rst = 1'b1;
    #1;
    chk("midrst_pinOut", 32'(pinOut), 32'h0);
    chk("midrst_pinOe", 32'(pinOe), 32'h0);
    tick();
    idle();
    rst = 1'b0;
    chk("midrst_nocommit", 32'(pinOut), 32'h0);
    chk("midrst_irq", 32'(changeIrq), 32'h0);

    // First edge after reset behaves normally
    bus.wrLatch = 1'b1; bus.wrData = 8'h77;
    tick();
    idle();
    chk("post_rst_wr", 32'(pinOut), 32'h007700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 The block SHALL take parameter NUM_PORTS, default 3, meaning the number of I/O ports (legal 1..4).
REQ-002 The block SHALL take parameter PORT_WIDTH, default 8, meaning the pins per port (legal 1..8).
REQ-003 The block SHALL take parameter DATA_WIDTH, default 8, meaning the core data bus width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 portSel  in  2  port index for the current access.
REQ-008 wrLatch  in  1  write strobe for the output latch.
REQ-009 wrTris  in  1  write strobe for the TRIS register (TRIS instruction).
REQ-010 rdEn  in  1  read strobe for the port.
REQ-011 wrData  in  DATA_WIDTH  write data; bits [PORT_WIDTH-1:0] are used.
REQ-012 rdData  out  DATA_WIDTH  registered read data.
REQ-013 pinIn  in  NUM_PORTS*PORT_WIDTH  raw pad inputs; port p occupies slice [p*PORT_WIDTH +: PORT_WIDTH].
REQ-014 pinOut  out  NUM_PORTS*PORT_WIDTH  output latch values.
REQ-015 pinOe  out  NUM_PORTS*PORT_WIDTH  pad drive enable, defined as the bitwise inverse of TRIS.
REQ-016 changeIrq  out  NUM_PORTS  per-port sticky change-on-input flags.

Function
REQ-017 Each pad bit SHALL pass through a 2-flop synchroniser (sync1, sync2).
- Any pin edge reaches sync2 after 2 clk edges.
REQ-018 On wrLatch with portSel<NUM_PORTS, latch[portSel] SHALL load wrData[PORT_WIDTH-1:0].
- pinOut changes on the same edge.
REQ-019 On wrTris with portSel<NUM_PORTS, tris[portSel] SHALL load wrData[PORT_WIDTH-1:0].
- tris bit = 1 means input; pinOe = ~tris.
REQ-020 On rdEn, rdData SHALL register sync2 of the selected port, zero-extended to DATA_WIDTH.
- Latency: 1 cycle.
- rdData holds its value when rdEn = 0.
REQ-021 A read SHALL return pin state (sync2) regardless of TRIS, so that read-modify-write reflects the pads.
REQ-022 If portSel>=NUM_PORTS, writes SHALL be ignored and a read SHALL return 0.
REQ-023 If wrLatch and wrTris are asserted in the same cycle, both registers SHALL update.
REQ-024 If rdEn and a write to the same port occur in the same cycle, the read SHALL return pre-edge sync2.
- The write does not bypass to rdData.
REQ-025 Each port SHALL keep a snapshot register.
- changeIrq[p] sets (sticky) when any bit has tris=1 and sync2 differs from snapshot.
REQ-026 A read of port p SHALL load snapshot[p] with sync2 and clear changeIrq[p] on the same edge.
- A mismatch that is present only in that cycle does not set the flag.
- A change arriving in sync2 on the next cycle sets the flag again.
REQ-027 Output-configured bits (tris=0) SHALL never set changeIrq.

Reset
REQ-028 On rst:
- latch = 0, so pinOut = 0.
- tris = all ones, so pinOe = 0.
- sync1, sync2 and snapshot = 0.
- rdData = 0.
- changeIrq = 0.
REQ-029 Reset SHALL take effect asynchronously, with no clock required.
REQ-030 Reset asserted mid-access SHALL abort the access; the write is not committed.
REQ-031 After rst deasserts, the first active edge SHALL behave normally.

Configuration
REQ-032 Macro GPIO_CHANGE_IRQ_EN defined: the snapshot registers and changeIrq logic (REQ-025..027) SHALL be present.
REQ-033 GPIO_CHANGE_IRQ_EN undefined: the snapshot logic SHALL be removed and changeIrq SHALL be tied to 0.
- All other behaviour is unchanged.

Verification
REQ-034 Reset check: assert rst with no clock -> pinOut=0, pinOe=0, rdData=0, changeIrq=0.
REQ-035 Port 1 output: wrTris port1 0x00, wrLatch port1 0xA5 -> next cycle pinOut[15:8]=0xA5, pinOe[15:8]=0xFF.
REQ-036 Synchroniser latency: pinIn[7:0]=0x3C with tris0=0xFF; rdEn port0 on cycles 1, 2 and 3 after the change.
- Reads launched on cycles 1 and 2 return the old value.
- The read on cycle 3 returns rdData=0x3C one cycle later.
REQ-037 Change flag: tris2=0x0F; toggle pinIn bit 20 -> changeIrq[2]=0 (output bit).
- Then toggle bit 16 -> changeIrq[2]=1 after 3 cycles.
- rdEn port2 -> flag cleared next edge.
REQ-038 Illegal port: NUM_PORTS=3, portSel=3, wrLatch 0xFF then rdEn -> no pinOut change, rdData=0.
REQ-039 Build without GPIO_CHANGE_IRQ_EN, repeat REQ-037 -> changeIrq stays 0; data paths identical.
